// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared state encodings and bus constants for mem_bus_arbiter
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    // Wide enough for any supported DATA_W; users slice down to their width.
    localparam int MAX_DATA_W = 256;
    localparam logic [MAX_DATA_W-1:0]   ZERO_WORD = '0;
    localparam logic [MAX_DATA_W/8-1:0] SEL_ALL   = '1;

endpackage

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - IF/MEM arbiter for the shared memory port; slave timeout enabled by MEM_BUS_ARB_TIMEOUT_EN
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ack,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_sel,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    input  logic                flush,
    output logic                s_cyc,
    output logic                s_we,
    output logic [DATA_W/8-1:0] s_sel,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic                s_ack,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                bus_err
);

    localparam int SEL_W = DATA_W / 8;

    arb_state_t state;
    logic       cancel;
    logic       i_pend;
    logic       d_pend;
    logic       tmo_hit;

    // A request whose ack is on the wire this cycle is already served;
    // masking it keeps the arbiter from re-granting a held req.
    assign i_pend    = i_req & ~i_ack;
    assign d_pend    = d_req & ~d_ack;
    assign stall_if  = i_pend & ~rst;
    assign stall_mem = d_pend & ~rst;

`ifdef MEM_BUS_ARB_TIMEOUT_EN
    localparam int TMO_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TMO_W   = (TMO_RAW > 8) ? TMO_RAW : 8;

    logic [TMO_W-1:0] tmo_cnt;

    // Fires in the busy cycle whose missing ack makes the count reach the limit.
    assign tmo_hit = (state != IDLE) && !s_ack && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Busy-cycle counter; held at zero while idle so it starts clean on each grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == IDLE) begin
            tmo_cnt <= '0;
        end else if (!s_ack) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES == 0);
    assign tmo_hit    = 1'b0;
`endif

    // Arbitration FSM: grants one master at a time, drives the slave, returns data/ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cancel  <= 1'b0;
            i_ack   <= 1'b0;
            i_rdata <= '0;
            d_ack   <= 1'b0;
            d_rdata <= '0;
            s_cyc   <= 1'b0;
            s_we    <= 1'b0;
            s_sel   <= '0;
            s_addr  <= '0;
            s_wdata <= '0;
            bus_err <= 1'b0;
        end else begin
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    cancel <= 1'b0;
                    if (d_pend) begin
                        state   <= BUSY_D;
                        s_cyc   <= 1'b1;
                        s_we    <= d_we;
                        s_sel   <= d_sel;
                        s_addr  <= d_addr;
                        s_wdata <= d_wdata;
                    end else if (i_pend && !flush) begin
                        state   <= BUSY_I;
                        s_cyc   <= 1'b1;
                        s_we    <= 1'b0;
                        s_sel   <= SEL_ALL[SEL_W-1:0];
                        s_addr  <= i_addr;
                        s_wdata <= ZERO_WORD[DATA_W-1:0];
                    end
                end
                BUSY_I: begin
                    if (s_ack || tmo_hit) begin
                        state   <= IDLE;
                        s_cyc   <= 1'b0;
                        cancel  <= 1'b0;
                        bus_err <= tmo_hit;
                        // A flushed fetch still finishes on the bus but is not delivered.
                        if (!(cancel || flush)) begin
                            i_ack   <= 1'b1;
                            i_rdata <= s_ack ? s_rdata : ZERO_WORD[DATA_W-1:0];
                        end
                    end else if (flush) begin
                        cancel <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (s_ack || tmo_hit) begin
                        state   <= IDLE;
                        s_cyc   <= 1'b0;
                        bus_err <= tmo_hit;
                        d_ack   <= 1'b1;
                        d_rdata <= (s_ack && !s_we) ? s_rdata : ZERO_WORD[DATA_W-1:0];
                    end
                end
                default: begin
                    state <= IDLE;
                    s_cyc <= 1'b0;
                end
            endcase
        end
    end

endmodule
